// File: rtl/fp32_div_pkg.sv
// Shared types and constants for the fp32 divider result path.
package fp32_div_pkg;

    localparam int unsigned EXC_W = 5;
    localparam int unsigned TAG_W = 4;
    localparam int unsigned Y_W   = 32;
    localparam int unsigned CNT_W = 16;

    typedef logic [EXC_W-1:0] exc_t;

    localparam int unsigned EXC_NV = 4;
    localparam int unsigned EXC_DZ = 3;
    localparam int unsigned EXC_OF = 2;
    localparam int unsigned EXC_UF = 1;
    localparam int unsigned EXC_NX = 0;

    localparam logic [Y_W-1:0] QNAN = 32'h7FC00000;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [Y_W-1:0]   y;
        exc_t             exc;
    } res_t;

    localparam int unsigned RES_W = $bits(res_t);

endpackage

// File: rtl/fp32_div_fifo2.sv
// Two-entry in-order FIFO with registered head and registered ready/valid.
module fp32_div_fifo2 #(
    parameter int unsigned W = 41
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         push_valid_i,
    output logic         push_ready_o,
    input  logic [W-1:0] push_data_i,
    output logic         pop_valid_o,
    input  logic         pop_ready_i,
    output logic [W-1:0] pop_data_o
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_e;

    occ_e         state_q;
    logic [W-1:0] head_q;
    logic [W-1:0] tail_q;
    logic         ready_q;
    logic         valid_q;
    logic         push;
    logic         pop;

    assign push = push_valid_i & ready_q;
    assign pop  = valid_q & pop_ready_i;

    // head_q is held at zero whenever the FIFO is empty so the output needs no masking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        head_q  <= push_data_i;
                        state_q <= ONE;
                        valid_q <= 1'b1;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_q <= push_data_i;
                    end else if (push) begin
                        tail_q  <= push_data_i;
                        state_q <= FULL;
                        ready_q <= 1'b0;
                    end else if (pop) begin
                        head_q  <= '0;
                        state_q <= EMPTY;
                        valid_q <= 1'b0;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_q  <= tail_q;
                        tail_q  <= '0;
                        state_q <= ONE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    head_q  <= '0;
                    tail_q  <= '0;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign push_ready_o = ready_q;
    assign pop_valid_o  = valid_q;
    assign pop_data_o   = head_q;

endmodule

// File: rtl/fp32_div_result_stage.sv
// Divider result stage: 2-entry result queue plus sticky fflags and commit counters.
module fp32_div_result_stage
    import fp32_div_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [Y_W-1:0]   in_y,
    input  logic [EXC_W-1:0] in_exc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic [Y_W-1:0]   out_y,
    output logic [EXC_W-1:0] out_exc,
    input  logic             flush,
    input  logic             fflags_clr,
    output logic [EXC_W-1:0] fflags,
    output logic [CNT_W-1:0] res_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (DEPTH != 2) begin : g_depth_check
        $error("fp32_div_result_stage: only DEPTH=2 is supported");
    end

    res_t             in_pl;
    res_t             out_pl;
    logic [RES_W-1:0] fifo_dout;
    logic             commit;
    logic             is_err;

    exc_t             fflags_q, fflags_d;
    logic [CNT_W-1:0] res_q, res_d;
    logic [CNT_W-1:0] err_q, err_d;

    assign in_pl.tag = in_tag;
    assign in_pl.y   = in_y;
    assign in_pl.exc = in_exc;

    fp32_div_fifo2 #(
        .W(RES_W)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush),
        .push_valid_i (in_valid),
        .push_ready_o (in_ready),
        .push_data_i  (RES_W'(in_pl)),
        .pop_valid_o  (out_valid),
        .pop_ready_i  (out_ready),
        .pop_data_o   (fifo_dout)
    );

    assign out_pl  = res_t'(fifo_dout);
    assign out_tag = out_pl.tag;
    assign out_y   = out_pl.y;
    assign out_exc = out_pl.exc;

    // A flushed head is discarded, so it must not touch flags or counters
    assign commit = out_valid & out_ready & ~flush;
    assign is_err = out_exc[EXC_NV] | out_exc[EXC_DZ];

    // Clear applies first so a same-cycle commit survives it
    always_comb begin
        fflags_d = fflags_clr ? '0 : fflags_q;
        res_d    = fflags_clr ? '0 : res_q;
        err_d    = fflags_clr ? '0 : err_q;
        if (commit) begin
            fflags_d = fflags_d | out_exc;
            if (res_d != CNT_MAX) res_d = res_d + CNT_W'(1);
            if (is_err && (err_d != CNT_MAX)) err_d = err_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fflags_q <= '0;
            res_q    <= '0;
            err_q    <= '0;
        end else begin
            fflags_q <= fflags_d;
            res_q    <= res_d;
            err_q    <= err_d;
        end
    end

    assign fflags  = fflags_q;
    assign res_cnt = res_q;
    assign err_cnt = err_q;

endmodule

// File: tb/tb_fp32_div_result_stage.sv
// Directed self-checking bench for fp32_div_result_stage.
module tb_fp32_div_result_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_tag;
    logic [31:0] in_y;
    logic [4:0]  in_exc;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_tag;
    logic [31:0] out_y;
    logic [4:0]  out_exc;
    logic        flush;
    logic        fflags_clr;
    logic [4:0]  fflags;
    logic [15:0] res_cnt;
    logic [15:0] err_cnt;

    int total = 0;
    int bad   = 0;

    fp32_div_result_stage #(.DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_tag     (in_tag),
        .in_y       (in_y),
        .in_exc     (in_exc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_tag    (out_tag),
        .out_y      (out_y),
        .out_exc    (out_exc),
        .flush      (flush),
        .fflags_clr (fflags_clr),
        .fflags     (fflags),
        .res_cnt    (res_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] t, input logic [31:0] y, input logic [4:0] e);
        in_valid = v;
        in_tag   = t;
        in_y     = y;
        in_exc   = e;
    endtask

    task automatic clear_stats();
        fflags_clr = 1'b1;
        cyc();
        fflags_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 4'd0, 32'd0, 5'd0);
        out_ready = 1'b0; flush = 1'b0; fflags_clr = 1'b0;
        #2;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if ({out_tag, out_y, out_exc} !== 41'd0) begin bad++; $display("FAIL reset_payload got=%h exp=0", {out_tag, out_y, out_exc}); end
        total++; if ({fflags, res_cnt, err_cnt} !== 37'd0) begin bad++; $display("FAIL reset_stats got=%h exp=0", {fflags, res_cnt, err_cnt}); end
        cyc(); cyc();
        rst = 1'b0;
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        drive(1'b1, 4'd1, 32'h3F800000, 5'd0);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_no_passthru got=%b exp=0", out_valid); end
        cyc();
        drive(1'b0, 4'd0, 32'd0, 5'd0);
        total++; if (out_valid !== 1'b1 || out_y !== 32'h3F800000 || out_tag !== 4'd1) begin
            bad++; $display("FAIL single_visible got v=%b y=%h tag=%0d exp v=1 y=3f800000 tag=1", out_valid, out_y, out_tag); end
        cyc();
        total++; if (out_valid !== 1'b0 || out_y !== 32'd0) begin bad++; $display("FAIL single_drained got v=%b y=%h exp v=0 y=0", out_valid, out_y); end
        total++; if (res_cnt !== 16'd1 || fflags !== 5'd0) begin bad++; $display("FAIL single_stats got res=%0d ff=%b exp res=1 ff=00000", res_cnt, fflags); end
    endtask

    task automatic test_stall_order();
        out_ready = 1'b0;
        drive(1'b1, 4'd1, 32'hA0000001, 5'd0);
        cyc();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_ready_one got=%b exp=1", in_ready); end
        drive(1'b1, 4'd2, 32'hA0000002, 5'd0);
        cyc();
        total++; if (in_ready !== 1'b0 || out_tag !== 4'd1) begin bad++; $display("FAIL stall_full got rdy=%b tag=%0d exp rdy=0 tag=1", in_ready, out_tag); end
        drive(1'b1, 4'd3, 32'hA0000003, 5'd0);
        cyc();
        total++; if (in_ready !== 1'b0 || out_tag !== 4'd1 || out_y !== 32'hA0000001) begin
            bad++; $display("FAIL stall_hold got rdy=%b tag=%0d y=%h exp rdy=0 tag=1 y=a0000001", in_ready, out_tag, out_y); end
        out_ready = 1'b1;
        cyc();
        total++; if (out_tag !== 4'd2 || out_y !== 32'hA0000002 || in_ready !== 1'b1) begin
            bad++; $display("FAIL stall_pop1 got tag=%0d y=%h rdy=%b exp tag=2 y=a0000002 rdy=1", out_tag, out_y, in_ready); end
        cyc();
        drive(1'b0, 4'd0, 32'd0, 5'd0);
        total++; if (out_tag !== 4'd3 || out_y !== 32'hA0000003) begin bad++; $display("FAIL stall_pop2 got tag=%0d y=%h exp tag=3 y=a0000003", out_tag, out_y); end
        cyc();
        total++; if (out_valid !== 1'b0 || res_cnt !== 16'd4) begin bad++; $display("FAIL stall_done got v=%b res=%0d exp v=0 res=4", out_valid, res_cnt); end
        out_ready = 1'b0;
        clear_stats();
        total++; if (res_cnt !== 16'd0) begin bad++; $display("FAIL clear_idle got res=%0d exp 0", res_cnt); end
    endtask

    task automatic test_flags();
        out_ready = 1'b1;
        drive(1'b1, 4'd4, 32'h7FC00000, 5'b10000);
        cyc();
        total++; if (out_y !== 32'h7FC00000 || out_exc !== 5'b10000) begin bad++; $display("FAIL flags_qnan got y=%h exc=%b exp y=7fc00000 exc=10000", out_y, out_exc); end
        drive(1'b1, 4'd5, 32'h7F800000, 5'b01000);
        cyc();
        drive(1'b1, 4'd6, 32'h00000001, 5'b00001);
        cyc();
        drive(1'b0, 4'd0, 32'd0, 5'd0);
        cyc();
        total++; if (fflags !== 5'b11001 || err_cnt !== 16'd2 || res_cnt !== 16'd3) begin
            bad++; $display("FAIL flags_accum got ff=%b err=%0d res=%0d exp ff=11001 err=2 res=3", fflags, err_cnt, res_cnt); end
        clear_stats();
    endtask

    task automatic test_clr_commit();
        out_ready = 1'b0;
        drive(1'b1, 4'd7, 32'h40000000, 5'b10010);
        cyc();
        drive(1'b0, 4'd0, 32'd0, 5'd0);
        out_ready = 1'b1;
        cyc();
        total++; if (fflags !== 5'b10010 || res_cnt !== 16'd1 || err_cnt !== 16'd1) begin
            bad++; $display("FAIL clr_pre got ff=%b res=%0d err=%0d exp ff=10010 res=1 err=1", fflags, res_cnt, err_cnt); end
        out_ready = 1'b0;
        drive(1'b1, 4'd8, 32'h7F7FFFFF, 5'b00100);
        cyc();
        drive(1'b0, 4'd0, 32'd0, 5'd0);
        out_ready = 1'b1; fflags_clr = 1'b1;
        cyc();
        fflags_clr = 1'b0; out_ready = 1'b0;
        total++; if (fflags !== 5'b00100 || res_cnt !== 16'd1 || err_cnt !== 16'd0) begin
            bad++; $display("FAIL clr_commit got ff=%b res=%0d err=%0d exp ff=00100 res=1 err=0", fflags, res_cnt, err_cnt); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 4'd9, 32'h11111111, 5'b11111);
        cyc();
        drive(1'b1, 4'd10, 32'h22222222, 5'b11111);
        cyc();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_full got rdy=%b exp 0", in_ready); end
        drive(1'b1, 4'd11, 32'h33333333, 5'b11111);
        flush = 1'b1; out_ready = 1'b1;
        cyc();
        flush = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_y !== 32'd0) begin
            bad++; $display("FAIL flush_empty got v=%b rdy=%b y=%h exp v=0 rdy=1 y=0", out_valid, in_ready, out_y); end
        total++; if (fflags !== 5'b00100 || res_cnt !== 16'd1 || err_cnt !== 16'd0) begin
            bad++; $display("FAIL flush_stats got ff=%b res=%0d err=%0d exp ff=00100 res=1 err=0", fflags, res_cnt, err_cnt); end
        drive(1'b0, 4'd0, 32'd0, 5'd0);
        cyc();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_push_dropped got v=%b exp 0", out_valid); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(1'b1, 4'd12, 32'h44444444, 5'd0);
        cyc(); cyc();
        drive(1'b0, 4'd0, 32'd0, 5'd0);
        #2 rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || res_cnt !== 16'd0 || fflags !== 5'd0) begin
            bad++; $display("FAIL async_rst got v=%b rdy=%b res=%0d ff=%b exp v=0 rdy=1 res=0 ff=0", out_valid, in_ready, res_cnt, fflags); end
        cyc();
        rst = 1'b0;
        drive(1'b1, 4'd13, 32'h55555555, 5'd0);
        cyc();
        drive(1'b0, 4'd0, 32'd0, 5'd0);
        total++; if (out_valid !== 1'b1 || out_tag !== 4'd13) begin bad++; $display("FAIL rst_first_push got v=%b tag=%0d exp v=1 tag=13", out_valid, out_tag); end
    endtask

    task automatic test_saturate();
        rst = 1'b1;
        #2 rst = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 4'd14, 32'h3F000000, 5'b10000);
        cyc();
        for (int i = 0; i < 65534; i++) cyc();
        total++; if (res_cnt !== 16'hFFFE || err_cnt !== 16'hFFFE) begin bad++; $display("FAIL sat_pre got res=%h err=%h exp fffe fffe", res_cnt, err_cnt); end
        cyc();
        total++; if (res_cnt !== 16'hFFFF || err_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_reach got res=%h err=%h exp ffff ffff", res_cnt, err_cnt); end
        cyc();
        total++; if (res_cnt !== 16'hFFFF || err_cnt !== 16'hFFFF || fflags !== 5'b10000) begin
            bad++; $display("FAIL sat_hold got res=%h err=%h ff=%b exp ffff ffff 10000", res_cnt, err_cnt, fflags); end
        drive(1'b0, 4'd0, 32'd0, 5'd0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall_order();
        test_flags();
        test_clr_commit();
        test_flush();
        test_async_reset();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
